// File: rtl/frame_ring_pkg.sv
// Shared types, default geometry constants and the free-buffer search used by
// the frame-buffer ring controller.
package frame_ring_pkg;

  typedef logic [1:0] buf_idx_t;

  localparam int DEFAULT_ADDR_W       = 20;
  localparam int DEFAULT_STRIDE       = 614400;
  localparam int DEFAULT_OFFSET_STEP  = 2300;
  localparam int DEFAULT_OFFSET_LIMIT = 32768;

  // Lowest buffer index that is neither the front nor the (valid) ready buffer.
  // Falls back to the front index when no buffer is free; callers guard that case.
  function automatic buf_idx_t next_free_idx(buf_idx_t front, buf_idx_t ready,
                                             logic ready_valid, int n);
    next_free_idx = front;
    for (int i = 3; i >= 0; i--) begin
      if (i < n && buf_idx_t'(i) != front && !(ready_valid && buf_idx_t'(i) == ready))
        next_free_idx = buf_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/detect_posedge.sv
// Rising-edge detector: registers the previous level and flags level & ~prev.
module DetectPosedge (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clock) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/frame_offset_gen.sv
// Per-frame SRAM offset generator: steps by OFFSET_STEP on each published frame
// and wraps to zero once the current offset has reached OFFSET_LIMIT.
module frame_offset_gen #(
  parameter int ADDR_W       = 20,
  parameter int OFFSET_STEP  = 2300,
  parameter int OFFSET_LIMIT = 32768
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              advance,
  output logic [ADDR_W-1:0] current,
  output logic [ADDR_W-1:0] stepped
);

  localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(OFFSET_STEP);
  localparam logic [ADDR_W-1:0] LIMIT_W = ADDR_W'(OFFSET_LIMIT);

  assign stepped = (current >= LIMIT_W) ? '0 : current + STEP_W;

  always_ff @(posedge clock) begin
    if (!reset_n)     current <= '0;
    else if (advance) current <= stepped;
  end

endmodule

// File: rtl/frame_ring_ctrl.sv
// N-buffer frame ring between rasterizer (back) and display (front) with a
// one-deep ready slot. Optional FRAME_STATS_EN adds dropped/repeated counters.
module frame_ring_ctrl
  import frame_ring_pkg::*;
#(
  parameter int          NUM_BUFFERS   = 3,
  parameter int          ADDR_W        = DEFAULT_ADDR_W,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int          BUFFER_STRIDE = DEFAULT_STRIDE,
  parameter int          OFFSET_STEP   = DEFAULT_OFFSET_STEP,
  parameter int          OFFSET_LIMIT  = DEFAULT_OFFSET_LIMIT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pause,
  input  logic              rf_completed_frame,
  input  logic              dc_completed_frame,
  output logic [ADDR_W-1:0] front_buffer_addr,
  output logic [ADDR_W-1:0] back_buffer_addr,
  output logic [1:0]        front_idx,
  output logic              rf_stall,
`ifdef FRAME_STATS_EN
  output logic [15:0]       dropped_frames,
  output logic [15:0]       repeated_frames,
`endif
  output logic              swapped
);

  buf_idx_t          front_q, back_q, ready_q;
  buf_idx_t          front_d, back_d, ready_d;
  logic              ready_valid_q, ready_valid_d;
  logic              pend_rf_q, pend_rf_d, pend_dc_q, pend_dc_d;
  logic              rf_stall_d, swapped_d, advance;
  logic              rf_ev, dc_ev, rf_req, dc_req;
  logic [ADDR_W-1:0] offset_q [4];
  logic [ADDR_W-1:0] offset_d [4];
  logic [ADDR_W-1:0] cur_offset, stepped_offset;
`ifdef FRAME_STATS_EN
  logic              drop, repeat_ev;
`endif

  DetectPosedge u_rf_edge (.clock(clock), .reset_n(reset_n), .level(rf_completed_frame), .pulse(rf_ev));
  DetectPosedge u_dc_edge (.clock(clock), .reset_n(reset_n), .level(dc_completed_frame), .pulse(dc_ev));

  frame_offset_gen #(
    .ADDR_W(ADDR_W), .OFFSET_STEP(OFFSET_STEP), .OFFSET_LIMIT(OFFSET_LIMIT)
  ) u_offset_gen (
    .clock(clock), .reset_n(reset_n), .advance(advance),
    .current(cur_offset), .stepped(stepped_offset)
  );

  assign rf_req = pend_rf_q | rf_ev;
  assign dc_req = pend_dc_q | dc_ev;

  // Producer step first, then consumer step sees the post-producer ready slot.
  always_comb begin
    front_d       = front_q;
    back_d        = back_q;
    ready_d       = ready_q;
    ready_valid_d = ready_valid_q;
    offset_d      = offset_q;
    pend_rf_d     = rf_req;
    pend_dc_d     = dc_req;
    advance       = 1'b0;
    swapped_d     = 1'b0;
`ifdef FRAME_STATS_EN
    drop          = 1'b0;
    repeat_ev     = 1'b0;
`endif
    if (!pause) begin
      if (rf_req && !(NUM_BUFFERS == 2 && ready_valid_q)) begin
`ifdef FRAME_STATS_EN
        drop          = ready_valid_q;
`endif
        ready_d       = back_q;
        ready_valid_d = 1'b1;
        pend_rf_d     = 1'b0;
        advance       = 1'b1;
        if (NUM_BUFFERS > 2) begin
          back_d           = next_free_idx(front_q, back_q, 1'b1, NUM_BUFFERS);
          offset_d[back_d] = stepped_offset;
        end
      end
      if (dc_req) begin
        pend_dc_d = 1'b0;
        if (ready_valid_d) begin
          front_d       = ready_d;
          ready_valid_d = 1'b0;
          swapped_d     = 1'b1;
          // With two buffers the freed front is the only possible new back.
          if (NUM_BUFFERS == 2) begin
            back_d            = front_q;
            offset_d[front_q] = advance ? stepped_offset : cur_offset;
          end
        end else begin
`ifdef FRAME_STATS_EN
          repeat_ev = 1'b1;
`endif
        end
      end
    end
    rf_stall_d = pend_rf_d && (NUM_BUFFERS == 2) && ready_valid_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      front_q       <= 2'd0;
      back_q        <= 2'd1;
      ready_q       <= 2'd0;
      ready_valid_q <= 1'b0;
      pend_rf_q     <= 1'b0;
      pend_dc_q     <= 1'b0;
      rf_stall      <= 1'b0;
      swapped       <= 1'b1;
      for (int i = 0; i < 4; i++) offset_q[i] <= '0;
    end else begin
      front_q       <= front_d;
      back_q        <= back_d;
      ready_q       <= ready_d;
      ready_valid_q <= ready_valid_d;
      pend_rf_q     <= pend_rf_d;
      pend_dc_q     <= pend_dc_d;
      rf_stall      <= rf_stall_d;
      swapped       <= swapped_d;
      offset_q      <= offset_d;
    end
  end

`ifdef FRAME_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dropped_frames  <= '0;
      repeated_frames <= '0;
    end else begin
      if (drop && dropped_frames != 16'hFFFF)       dropped_frames  <= dropped_frames + 16'd1;
      if (repeat_ev && repeated_frames != 16'hFFFF) repeated_frames <= repeated_frames + 16'd1;
    end
  end
`endif

  assign front_idx         = front_q;
  assign front_buffer_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(32'(front_q) * BUFFER_STRIDE) + offset_q[front_q];
  assign back_buffer_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(32'(back_q) * BUFFER_STRIDE) + offset_q[back_q];

endmodule

// File: tb/tb_frame_ring_ctrl.sv
// Directed self-checking bench for frame_ring_ctrl (N=3 and N=2 instances);
// stats checks are compiled in when FRAME_STATS_EN is defined.
module tb_frame_ring_ctrl;

  logic        clock = 1'b0;
  logic        reset_n, pause, rf, dc;
  logic        pause2, rf2, dc2;
  logic [19:0] front_addr, back_addr, front_addr2, back_addr2;
  logic [1:0]  front_idx, front_idx2;
  logic        rf_stall, swapped, rf_stall2, swapped2;
`ifdef FRAME_STATS_EN
  logic [15:0] dropped, repeated, dropped2, repeated2;
`endif
  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  frame_ring_ctrl #(.NUM_BUFFERS(3)) u3 (
    .clock(clock), .reset_n(reset_n), .pause(pause),
    .rf_completed_frame(rf), .dc_completed_frame(dc),
    .front_buffer_addr(front_addr), .back_buffer_addr(back_addr),
    .front_idx(front_idx), .rf_stall(rf_stall),
`ifdef FRAME_STATS_EN
    .dropped_frames(dropped), .repeated_frames(repeated),
`endif
    .swapped(swapped)
  );

  frame_ring_ctrl #(.NUM_BUFFERS(2)) u2 (
    .clock(clock), .reset_n(reset_n), .pause(pause2),
    .rf_completed_frame(rf2), .dc_completed_frame(dc2),
    .front_buffer_addr(front_addr2), .back_buffer_addr(back_addr2),
    .front_idx(front_idx2), .rf_stall(rf_stall2),
`ifdef FRAME_STATS_EN
    .dropped_frames(dropped2), .repeated_frames(repeated2),
`endif
    .swapped(swapped2)
  );

  // Advance n rising edges, then settle 2 time units past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic p, input logic r, input logic d);
    pause = p;
    rf    = r;
    dc    = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] addr_of(input int idx, input int off);
    addr_of = (idx * 614400 + off) & 32'h000F_FFFF;
  endfunction

  initial begin
    int f_idx, b_idx, nb, exp_off;

    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    pause2 = 1'b0; rf2 = 1'b0; dc2 = 1'b0;
    step(2);
    checkOutput("reset_swapped", swapped, 1);
    checkOutput("reset_front_idx", front_idx, 0);
    checkOutput("reset_front_addr", front_addr, 0);
    checkOutput("reset_back_addr", back_addr, 614400);
    checkOutput("reset_rf_stall", rf_stall, 0);

    reset_n = 1'b1;
    step(1);
    checkOutput("post_reset_swapped", swapped, 0);

    // First frame published into ready: back moves to buffer 2 at offset 2300.
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("pub1_front_idx", front_idx, 0);
    checkOutput("pub1_swapped", swapped, 0);
    checkOutput("pub1_back_addr", back_addr, addr_of(2, 2300));
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(9);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("flip1_front_idx", front_idx, 1);
    checkOutput("flip1_front_addr", front_addr, 614400);
    checkOutput("flip1_swapped", swapped, 1);
    checkOutput("flip1_back_addr", back_addr, addr_of(2, 2300));
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("flip1_pulse_end", swapped, 0);

    // Two publishes without a flip: the second overwrites the ready slot.
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("pub2_back_addr", back_addr, addr_of(0, 4600));
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(1);
    checkOutput("pub3_back_addr", back_addr, addr_of(2, 6900));
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("flip2_front_idx", front_idx, 0);
    checkOutput("flip2_front_addr", front_addr, 4600);
    checkOutput("flip2_swapped", swapped, 1);
`ifdef FRAME_STATS_EN
    checkOutput("dropped_frames", dropped, 1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);

    // Display frame end with nothing ready: frame repeats.
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("repeat_front_idx", front_idx, 0);
    checkOutput("repeat_swapped", swapped, 0);
`ifdef FRAME_STATS_EN
    checkOutput("repeated_frames", repeated, 1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);

    // Both events arrive while paused; one swap on the first unpaused cycle.
    applyStimulus(1'b1, 1'b1, 1'b1);
    step(1);
    checkOutput("pause_swapped", swapped, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(4);
    checkOutput("pause_front_idx", front_idx, 0);
    checkOutput("pause_swapped_hold", swapped, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("unpause_front_idx", front_idx, 2);
    checkOutput("unpause_front_addr", front_addr, addr_of(2, 6900));
    checkOutput("unpause_back_addr", back_addr, addr_of(1, 9200));
    checkOutput("unpause_swapped", swapped, 1);
    step(1);
    checkOutput("unpause_pulse_end", swapped, 0);

    // Frames 4..16 go straight to front; offset is 2300*k, wrapping to 0 at 16.
    f_idx = 2;
    b_idx = 1;
    for (int k = 4; k <= 16; k++) begin
      nb = 0;
      while (nb == f_idx || nb == b_idx) nb++;
      f_idx   = b_idx;
      b_idx   = nb;
      exp_off = (k <= 15) ? 2300 * k : 0;
      applyStimulus(1'b0, 1'b1, 1'b1);
      step(1);
      checkOutput($sformatf("seq_front_addr_%0d", k), front_addr, addr_of(f_idx, exp_off));
      applyStimulus(1'b0, 1'b0, 1'b0);
      step(1);
    end

    // Two-buffer ring: second publish must stall until the display flips.
    rf2 = 1'b1;
    step(1);
    checkOutput("n2_pub1_stall", rf_stall2, 0);
    rf2 = 1'b0;
    step(1);
    rf2 = 1'b1;
    step(1);
    checkOutput("n2_stall", rf_stall2, 1);
    checkOutput("n2_stall_front_idx", front_idx2, 0);
    rf2 = 1'b0;
    step(1);
    checkOutput("n2_stall_hold", rf_stall2, 1);
    dc2 = 1'b1;
    step(1);
    checkOutput("n2_flip_front_idx", front_idx2, 1);
    checkOutput("n2_flip_swapped", swapped2, 1);
    checkOutput("n2_flip_stall", rf_stall2, 0);
    dc2 = 1'b0;
    step(1);
    checkOutput("n2_served_stall", rf_stall2, 0);
    checkOutput("n2_served_swapped", swapped2, 0);
    dc2 = 1'b1;
    step(1);
    checkOutput("n2_flip2_front_idx", front_idx2, 0);
    checkOutput("n2_flip2_front_addr", front_addr2, 2300);
    dc2 = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
